pc_sequencer: RTL and testbench

Sequences the program counter around the branch unit.
- Issues instruction fetches over a req/ack handshake and presents one instruction per execute slot.
- Selects the next PC from the branch unit's jmp/branch/offset/target outputs and the datapath's equality result.
- Optionally defers redirects by one architectural branch delay slot.
- Sits between instruction memory and the decode/branch logic, and owns the only PC register in the core.

---
 rtl/pc_sequencer_pkg.sv | 22 ++
 rtl/pc_sequencer_npc_sel.sv | 24 ++
 rtl/pc_sequencer.sv | 115 +++++++++++
 tb/tb_pc_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: state encoding,
// word stride and the default reset vector.
package pc_sequencer_pkg;

  localparam logic [1:0]  ST_RST   = 2'd0;
  localparam logic [1:0]  ST_FETCH = 2'd1;
  localparam logic [1:0]  ST_EXEC  = 2'd2;

  localparam logic [31:0] WORD             = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_RST   = ST_RST,
    S_FETCH = ST_FETCH,
    S_EXEC  = ST_EXEC
  } state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_sequencer_npc_sel.sv
// Combinational next-PC select: jump beats taken branch beats fall-through,
// and the result is always word aligned.
module npc_sel
  import pc_sequencer_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [31:0] offset,
  input  logic [31:0] target,
  input  logic        jmp,
  input  logic        branch,
  input  logic        br_eq,
  output logic [31:0] npc
);

  always_comb begin
    npc = word_align(pc_plus4);
    if (jmp) begin
      npc = word_align(target);
    end else if (branch && br_eq) begin
      npc = word_align(pc_plus4 + offset);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Owns the core PC: fetch handshake, one execute slot per instruction,
// next-PC update with optional single branch delay slot, retire counter.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter bit          DELAY_SLOT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  output logic        instr_valid,
  input  logic        stall,
  input  logic        jmp,
  input  logic        branch,
  input  logic        br_eq,
  input  logic [31:0] offset,
  input  logic [31:0] target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        redirect,
  output logic [31:0] retire_cnt
);

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] pend_pc_q;
  logic        pending_q;
  logic        req_q;
  logic        valid_q;
  logic        redirect_q;
  logic [31:0] cnt_q;

  logic [31:0] pc_plus4_d;
  logic [31:0] npc_d;
  logic        taken_d;

  assign pc_plus4_d = pc_q + WORD;
  assign taken_d    = jmp | (branch & br_eq);

  npc_sel u_npc_sel (
    .pc_plus4 (pc_plus4_d),
    .offset   (offset),
    .target   (target),
    .jmp      (jmp),
    .branch   (branch),
    .br_eq    (br_eq),
    .npc      (npc_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RST;
      pc_q       <= word_align(RESET_PC);
      pend_pc_q  <= '0;
      pending_q  <= 1'b0;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      redirect_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      redirect_q <= 1'b0;
      case (state_q)
        S_RST: begin
          state_q <= S_FETCH;
          req_q   <= 1'b1;
        end
        S_FETCH: begin
          if (imem_ack) begin
            state_q <= S_EXEC;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        S_EXEC: begin
          if (!stall) begin
            state_q <= S_FETCH;
            req_q   <= 1'b1;
            valid_q <= 1'b0;
            cnt_q   <= cnt_q + 32'd1;
            // In the delay slot any new jmp/branch is ignored; the stored target wins.
            if (DELAY_SLOT && pending_q) begin
              pc_q       <= pend_pc_q;
              pending_q  <= 1'b0;
              redirect_q <= 1'b1;
            end else if (DELAY_SLOT && taken_d) begin
              pend_pc_q <= npc_d;
              pending_q <= 1'b1;
              pc_q      <= word_align(pc_plus4_d);
            end else begin
              pc_q       <= npc_d;
              redirect_q <= taken_d;
            end
          end
        end
        default: begin
          state_q <= S_RST;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_plus4_d;
  assign redirect    = redirect_q;
  assign retire_cnt  = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: immediate-redirect and delay-slot instances driven
// from instruction tables, with retire results checked through a queue.
module tb_pc_sequencer;

  typedef struct {
    logic [31:0] pc;
    logic        jmp;
    logic        branch;
    logic        br_eq;
    logic [31:0] offset;
    logic [31:0] target;
    int          stall_n;
    logic [31:0] npc;
    logic        red;
  } vec_t;

  typedef struct {
    logic [31:0] npc;
    logic        red;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst0, rst1, ack, sel;
  logic        stall, jmp, branch, br_eq;
  logic [31:0] offset, target;
  logic        ack0, ack1;

  logic        req0, req1, val0, val1, red0, red1;
  logic [31:0] addr0, addr1, pc0, pc1, pc4_0, pc4_1, cnt0, cnt1;

  logic        m_req, m_val, m_red;
  logic [31:0] m_addr, m_pc, m_pc4, m_cnt;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_cnt;
  exp_t        sb_q[$];
  vec_t        v0[14];
  vec_t        v1[6];

  always #5 clk = ~clk;

  assign ack0 = ack & ~sel;
  assign ack1 = ack & sel;

  always_comb begin
    m_req  = sel ? req1  : req0;
    m_val  = sel ? val1  : val0;
    m_red  = sel ? red1  : red0;
    m_addr = sel ? addr1 : addr0;
    m_pc   = sel ? pc1   : pc0;
    m_pc4  = sel ? pc4_1 : pc4_0;
    m_cnt  = sel ? cnt1  : cnt0;
  end

  pc_sequencer #(.RESET_PC(32'h0000_3000), .DELAY_SLOT(1'b0)) dut0 (
    .clk(clk), .rst(rst0), .imem_req(req0), .imem_addr(addr0), .imem_ack(ack0),
    .instr_valid(val0), .stall(stall), .jmp(jmp), .branch(branch), .br_eq(br_eq),
    .offset(offset), .target(target), .pc(pc0), .pc_plus4(pc4_0),
    .redirect(red0), .retire_cnt(cnt0)
  );

  pc_sequencer #(.RESET_PC(32'h0000_3000), .DELAY_SLOT(1'b1)) dut1 (
    .clk(clk), .rst(rst1), .imem_req(req1), .imem_addr(addr1), .imem_ack(ack1),
    .instr_valid(val1), .stall(stall), .jmp(jmp), .branch(branch), .br_eq(br_eq),
    .offset(offset), .target(target), .pc(pc1), .pc_plus4(pc4_1),
    .redirect(red1), .retire_cnt(cnt1)
  );

  function automatic vec_t mk(input logic [31:0] pc, input logic j, input logic b,
                              input logic e, input logic [31:0] off, input logic [31:0] tgt,
                              input int sn, input logic [31:0] npc, input logic red);
    vec_t v;
    v.pc = pc; v.jmp = j; v.branch = b; v.br_eq = e; v.offset = off;
    v.target = tgt; v.stall_n = sn; v.npc = npc; v.red = red;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int   n;
    exp_t e;
    n = 0;
    while (m_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", {31'd0, m_req}, 32'd1);
    chk("fetch_addr", m_addr, v.pc);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("exec_valid", {31'd0, m_val}, 32'd1);
    chk("exec_pc", m_pc, v.pc);
    chk("exec_pc4", m_pc4, v.pc + 32'd4);
    chk("redirect_one_cycle", {31'd0, m_red}, 32'd0);
    jmp = v.jmp; branch = v.branch; br_eq = v.br_eq;
    offset = v.offset; target = v.target;
    stall = (v.stall_n > 0);
    exp_cnt = exp_cnt + 32'd1;
    e.npc = v.npc; e.red = v.red; e.cnt = exp_cnt;
    sb_q.push_back(e);
    for (int i = 0; i < v.stall_n; i++) begin
      @(negedge clk);
      chk("stall_pc", m_pc, v.pc);
      chk("stall_valid", {31'd0, m_val}, 32'd1);
      chk("stall_cnt", m_cnt, exp_cnt - 32'd1);
    end
    stall = 1'b0;
    @(negedge clk);
    jmp = 1'b0; branch = 1'b0; br_eq = 1'b0; offset = '0; target = '0;
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk("retire_pc", m_pc, e.npc);
      chk("retire_redirect", {31'd0, m_red}, {31'd0, e.red});
      chk("retire_cnt", m_cnt, e.cnt);
      chk("retire_valid", {31'd0, m_val}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    v0[0]  = mk(32'h0000_3000, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0000_3004, 0);
    v0[1]  = mk(32'h0000_3004, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0000_3008, 0);
    v0[2]  = mk(32'h0000_3008, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0000_300C, 0);
    v0[3]  = mk(32'h0000_300C, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0000_3010, 0);
    v0[4]  = mk(32'h0000_3010, 0, 1, 1, 32'hFFFF_FFF0, 32'h0, 0, 32'h0000_3004, 1);
    v0[5]  = mk(32'h0000_3004, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0000_3008, 0);
    v0[6]  = mk(32'h0000_3008, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0000_300C, 0);
    v0[7]  = mk(32'h0000_300C, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0000_3010, 0);
    v0[8]  = mk(32'h0000_3010, 0, 1, 0, 32'hFFFF_FFF0, 32'h0, 0, 32'h0000_3014, 0);
    v0[9]  = mk(32'h0000_3014, 1, 1, 1, 32'h0000_0100, 32'h0040_0000, 3, 32'h0040_0000, 1);
    v0[10] = mk(32'h0040_0000, 1, 0, 0, 32'h0, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 1);
    v0[11] = mk(32'hFFFF_FFFC, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0000_0000, 0);
    v0[12] = mk(32'h0000_0000, 1, 0, 0, 32'h0, 32'h0000_1237, 0, 32'h0000_1234, 1);
    v0[13] = mk(32'h0000_1234, 0, 1, 1, 32'h0000_0003, 32'h0, 0, 32'h0000_1238, 1);

    v1[0]  = mk(32'h0000_3000, 1, 0, 0, 32'h0, 32'h0000_3100, 0, 32'h0000_3004, 0);
    v1[1]  = mk(32'h0000_3004, 1, 0, 0, 32'h0, 32'h0000_3200, 1, 32'h0000_3100, 1);
    v1[2]  = mk(32'h0000_3100, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0000_3104, 0);
    v1[3]  = mk(32'h0000_3104, 0, 1, 0, 32'h0000_0008, 32'h0, 0, 32'h0000_3108, 0);
    v1[4]  = mk(32'h0000_3108, 0, 1, 1, 32'h0000_0008, 32'h0, 0, 32'h0000_310C, 0);
    v1[5]  = mk(32'h0000_310C, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0000_3114, 1);

    sel = 1'b0; rst0 = 1'b1; rst1 = 1'b1; ack = 1'b1;
    stall = 1'b0; jmp = 1'b0; branch = 1'b0; br_eq = 1'b0;
    offset = '0; target = '0; exp_cnt = '0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_req", {31'd0, m_req}, 32'd0);
      chk("rst_pc", m_pc, 32'h0000_3000);
      chk("rst_cnt", m_cnt, 32'd0);
      chk("rst_valid", {31'd0, m_val}, 32'd0);
      chk("rst_redirect", {31'd0, m_red}, 32'd0);
    end
    rst0 = 1'b0;
    @(negedge clk);
    chk("release_req", {31'd0, m_req}, 32'd1);
    chk("release_valid", {31'd0, m_val}, 32'd0);
    ack = 1'b0;

    for (int i = 0; i < 14; i++) run_vec(v0[i]);

    // reset lands on the same edge as a fetch ack: nothing retires
    chk("pre_rst_req", {31'd0, m_req}, 32'd1);
    rst0 = 1'b1; ack = 1'b1;
    @(negedge clk);
    rst0 = 1'b0; ack = 1'b0;
    chk("rst_ack_pc", m_pc, 32'h0000_3000);
    chk("rst_ack_cnt", m_cnt, 32'd0);
    chk("rst_ack_valid", {31'd0, m_val}, 32'd0);
    chk("rst_ack_req", {31'd0, m_req}, 32'd0);
    exp_cnt = '0;
    run_vec(mk(32'h0000_3000, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0000_3004, 0));

    sel = 1'b1;
    rst1 = 1'b0;
    exp_cnt = '0;
    @(negedge clk);
    for (int i = 0; i < 6; i++) run_vec(v1[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
